// File: rtl/convert_8_64_pkg.sv
// Purpose : shared widths and FSM encoding for the 8->64 byte packer.
// Latency : n/a (declarations only).
// Backpr. : n/a (declarations only).
package convert_8_64_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 64;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD);
  // Byte count has to reach 8, one bit wider than the lane index.
  localparam int NB_W           = CNT_W + 1;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/convert_8_64.sv
// Purpose : packs bytes little-endian into 64-bit words; i_last flushes a zero-padded partial word.
// Latency : word is presented the cycle after its completing byte is accepted.
// Backpr. : holds the word until i_trdy; o_rrdy low in HOLD unless i_trdy frees the slot this cycle.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   i_data/i_rval/i_last  input byte stream, o_rrdy back to the sender
//   o_data/o_nbytes       assembled word (byte k in lane k) and its valid byte count 1..8
//   o_tval/i_trdy         output word handshake
module convert_8_64
  import convert_8_64_pkg::*;
#(
  parameter bit LAST_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_rval,
  input  logic              i_last,
  output logic              o_rrdy,
  output logic [WORD_W-1:0] o_data,
  output logic [NB_W-1:0]   o_nbytes,
  output logic              o_tval,
  input  logic              i_trdy
);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic [NB_W-1:0]   out_nbytes_q, out_nbytes_d;
  logic              tval_q, tval_d;

  logic [WORD_W-1:0] acc_wr;
  logic              i_xfer;
  logic              o_xfer;
  logic              word_done;

  assign i_xfer    = i_rval & o_rrdy;
  assign o_xfer    = tval_q & i_trdy;
  assign word_done = i_xfer &
                     ((byte_cnt_q == CNT_W'(BYTES_PER_WORD - 1)) | (LAST_EN & i_last));

  // Current byte dropped into lane byte_cnt. In HOLD the accumulator is
  // already cleared and byte_cnt is 0, so a back-to-back byte lands in lane 0
  // without any special casing. Unwritten lanes stay zero, which is the padding.
  always_comb begin
    acc_wr = acc_q;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      if (byte_cnt_q == CNT_W'(k)) begin
        acc_wr[k*BYTE_W +: BYTE_W] = i_data;
      end
    end
  end

  // State register and datapath flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_COLLECT;
      acc_q        <= '0;
      byte_cnt_q   <= '0;
      out_data_q   <= '0;
      out_nbytes_q <= '0;
      tval_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      byte_cnt_q   <= byte_cnt_d;
      out_data_q   <= out_data_d;
      out_nbytes_q <= out_nbytes_d;
      tval_q       <= tval_d;
    end
  end

  // Next state. A lone i_last byte accepted while the held word drains
  // completes immediately, so the FSM stays in HOLD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: if (word_done)           state_d = ST_HOLD;
      ST_HOLD:    if (o_xfer & ~word_done) state_d = ST_COLLECT;
      default:                             state_d = ST_COLLECT;
    endcase
  end

  // Datapath next values.
  always_comb begin
    acc_d        = acc_q;
    byte_cnt_d   = byte_cnt_q;
    out_data_d   = out_data_q;
    out_nbytes_d = out_nbytes_q;
    tval_d       = tval_q;

    if (o_xfer) begin
      tval_d = 1'b0;
    end

    if (word_done) begin
      out_data_d   = acc_wr;
      out_nbytes_d = NB_W'(byte_cnt_q) + NB_W'(1);
      tval_d       = 1'b1;
      acc_d        = '0;
      byte_cnt_d   = '0;
    end else if (i_xfer) begin
      acc_d      = acc_wr;
      byte_cnt_d = byte_cnt_q + CNT_W'(1);
    end
  end

  // Outputs. Ready depends on i_trdy only, never on i_rval.
  always_comb begin
    o_rrdy = 1'b0;
    case (state_q)
      ST_COLLECT: o_rrdy = 1'b1;
      ST_HOLD:    o_rrdy = i_trdy;
      default:    o_rrdy = 1'b0;
    endcase
  end

  assign o_data   = out_data_q;
  assign o_nbytes = out_nbytes_q;
  assign o_tval   = tval_q;

endmodule
